// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stack_pkg
// Brief    : Opcodes, state encoding and helpers shared by the stack sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_NOP  = 3'd0;
    localparam logic [OPW-1:0] OP_ADD  = 3'd1;
    localparam logic [OPW-1:0] OP_SUB  = 3'd2;
    localparam logic [OPW-1:0] OP_MUL  = 3'd3;
    localparam logic [OPW-1:0] OP_PUSH = 3'd4;
    localparam logic [OPW-1:0] OP_NEG  = 3'd5;
    localparam logic [OPW-1:0] OP_AND  = 3'd6;
    localparam logic [OPW-1:0] OP_OR   = 3'd7;

    // Capacity of the downstream stack machine, used by the optional depth check
    localparam int STACK_S = 8;
    localparam int DEPTH_W = $clog2(STACK_S) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic is_binary_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_prog_mem
// Brief    : Program store, synchronous write / asynchronous read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module stack_prog_mem
    import stack_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [OPW-1:0] wop_i,
    input  logic [N-1:0]   wimm_i,
    input  logic [AW-1:0]  raddr_i,
    output logic [OPW-1:0] rop_o,
    output logic [N-1:0]   rimm_o
);

    logic [OPW+N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wop_i, wimm_i};
        end
    end

    assign rop_o  = mem_q[raddr_i][OPW+N-1:N];
    assign rimm_o = mem_q[raddr_i][N-1:0];

endmodule
`default_nettype wire

// File: rtl/stack_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_prog_sequencer
// Brief    : Loads an opcode/immediate program and issues it to the stack
//            machine one instruction per cycle, then captures the result.
//            Optional macro STACK_DEPTH_CHECK_EN adds stack depth fault abort.
// Revision : 1.0 - initial release
// ============================================================================
module stack_prog_sequencer
    import stack_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [OPW-1:0] load_op,
    input  logic [N-1:0]   load_imm,
    input  logic           load_last,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [OPW-1:0] op_out,
    output logic [N-1:0]   imm_out,
    input  logic [N-1:0]   result_in,
    output logic [N-1:0]   result_out,
    output logic [AW-1:0]  pc
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    prog_len_q, prog_len_d;
    logic           sealed_q, sealed_d;
    logic           done_q, done_d;
    logic [N-1:0]   result_q, result_d;
    logic [OPW-1:0] op_q, op_d;
    logic [N-1:0]   imm_q, imm_d;

    logic           w_go;
    logic           w_acc;
    logic           w_last_pc;
    logic           w_fault;
    logic [AW-1:0]  w_rd_addr;
    logic [OPW-1:0] w_rd_op;
    logic [N-1:0]   w_rd_imm;

    // A valid start pre-empts any load offered in the same cycle
    assign w_go       = (state_q == ST_IDLE) && start && sealed_q && (prog_len_q != '0);
    assign load_ready = (state_q == ST_IDLE) && (wr_ptr_q < c_DEPTH) && !w_go;
    assign w_acc      = load_valid && load_ready;
    assign w_last_pc  = ({1'b0, pc_q} == (prog_len_q - (AW+1)'(1)));
    assign w_rd_addr  = (state_q == ST_RUN) ? (pc_q + AW'(1)) : '0;

    stack_prog_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wop_i   (load_op),
        .wimm_i  (load_imm),
        .raddr_i (w_rd_addr),
        .rop_o   (w_rd_op),
        .rimm_o  (w_rd_imm)
    );

`ifdef STACK_DEPTH_CHECK_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;

    // Evaluated against the instruction currently on op_out
    always_comb begin
        w_fault = 1'b0;
        if (op_q == OP_PUSH) begin
            w_fault = (depth_q == DEPTH_W'(STACK_S));
        end else if (op_q == OP_NEG) begin
            w_fault = (depth_q == '0);
        end else if (is_binary_op(op_q)) begin
            w_fault = (depth_q < DEPTH_W'(2));
        end
    end

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        if (w_go) begin
            depth_d = '0;
            err_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (w_fault) begin
                err_d = 1'b1;
            end else if (op_q == OP_PUSH) begin
                depth_d = depth_q + DEPTH_W'(1);
            end else if (is_binary_op(op_q)) begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign w_fault = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        sealed_d   = sealed_q;
        done_d     = 1'b0;
        result_d   = result_q;
        op_d       = OP_NOP;
        imm_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_go) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    op_d    = w_rd_op;
                    imm_d   = w_rd_imm;
                end else if (w_acc) begin
                    if (sealed_q) begin
                        sealed_d   = 1'b0;
                        prog_len_d = '0;
                    end
                    if (load_last) begin
                        prog_len_d = wr_ptr_q + (AW+1)'(1);
                        sealed_d   = 1'b1;
                        wr_ptr_d   = '0;
                    end else begin
                        wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
                    end
                end
            end
            ST_RUN: begin
                if (w_fault || w_last_pc) begin
                    state_d = ST_DRAIN;
                    pc_d    = '0;
                end else begin
                    pc_d  = pc_q + AW'(1);
                    op_d  = w_rd_op;
                    imm_d = w_rd_imm;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_IDLE;
                result_d = result_in;
                done_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            sealed_q   <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            op_q       <= OP_NOP;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            sealed_q   <= sealed_d;
            done_q     <= done_d;
            result_q   <= result_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
        end
    end

    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = done_q;
    assign result_out = result_q;
    assign op_out     = op_q;
    assign imm_out    = imm_q;
    assign pc         = pc_q;

endmodule
`default_nettype wire
